// File: rtl/score_pkg.sv
// Shared types and constants for the score sequencer and its score-register bus.
package score_pkg;

    typedef enum logic [2:0] {
        StClr1  = 3'd0,
        StClr2  = 3'd1,
        StPlay  = 3'd2,
        StWr1   = 3'd3,
        StWr2   = 3'd4,
        StPause = 3'd5,
        StOver  = 3'd6
    } score_state_t;

    localparam logic [1:0] SCORE1_ADDR = 2'b00;
    localparam logic [1:0] SCORE2_ADDR = 2'b01;
    localparam int unsigned SCORE_W = 4;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/frame_delay.sv
// Counts qualified frame ticks after a clear; done pulses on the PAUSE_FRAMES-th tick.
module frame_delay #(
    parameter int unsigned PAUSE_FRAMES = 60
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic done
);

    localparam int unsigned CNT_W = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PAUSE_FRAMES - 1);

    logic [CNT_W-1:0] cnt_q;

    assign done = tick && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (done) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/score_sequencer.sv
// Owns both player scores, sequences score-register writes, pauses after goals, ends the game.
import score_pkg::*;

module score_sequencer #(
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned PAUSE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        goal_p1_i,
    input  logic        goal_p2_i,
    input  logic        new_game_i,
    input  logic        frame_tick_i,
    output logic        MW_o,
    output logic [1:0]  address_o,
    output logic [31:0] data_o,
    output logic        freeze_o,
    output logic        game_over_o,
    output logic [1:0]  winner_o
);

    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    score_state_t       state_q, state_d;
    logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [1:0]         winner_q, winner_d;
    logic               mw_q, mw_d;
    logic [1:0]         addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               freeze_q, freeze_d;
    logic               over_q, over_d;
    logic               pause_done;
    logic               s1_won, s2_won;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v >= WIN) ? WIN : v + 1'b1;
    endfunction

    frame_delay #(
        .PAUSE_FRAMES(PAUSE_FRAMES)
    ) u_frame_delay (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q == StWr2),
        .tick (frame_tick_i && (state_q == StPause)),
        .done (pause_done)
    );

    assign s1_won = (s1_q == WIN);
    assign s2_won = (s2_q == WIN);

    always_comb begin
        state_d  = state_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        winner_d = winner_q;
        if (new_game_i && (state_q != StClr1) && (state_q != StClr2)) begin
            state_d = StClr1;
        end else begin
            unique case (state_q)
                // After reset the CLR1 write has not been issued yet, so hold one cycle to emit it.
                StClr1: if (mw_q) state_d = StClr2;
                StClr2: state_d = StPlay;
                StPlay: begin
                    if (goal_p1_i || goal_p2_i) begin
                        if (goal_p1_i) s1_d = sat_inc(s1_q);
                        if (goal_p2_i) s2_d = sat_inc(s2_q);
                        state_d = StWr1;
                    end
                end
                StWr1: state_d = StWr2;
                StWr2: begin
                    if (s1_won || s2_won) begin
                        state_d = StOver;
                        if (s1_won && s2_won) winner_d = WIN_DRAW;
                        else if (s1_won)      winner_d = WIN_P1;
                        else                  winner_d = WIN_P2;
                    end else begin
                        state_d = StPause;
                    end
                end
                StPause: if (pause_done) state_d = StPlay;
                StOver:  state_d = StOver;
                default: state_d = StClr1;
            endcase
        end
        if (state_d == StClr1) begin
            s1_d     = '0;
            s2_d     = '0;
            winner_d = WIN_NONE;
        end
    end

    // Outputs are decoded from the state being entered so they line up with that state.
    always_comb begin
        mw_d     = 1'b0;
        addr_d   = SCORE1_ADDR;
        data_d   = '0;
        freeze_d = 1'b1;
        over_d   = 1'b0;
        unique case (state_d)
            StClr1: mw_d = 1'b1;
            StClr2: begin
                mw_d   = 1'b1;
                addr_d = SCORE2_ADDR;
            end
            StPlay: freeze_d = 1'b0;
            StWr1: begin
                mw_d   = 1'b1;
                data_d = {{(32 - SCORE_W){1'b0}}, s1_d};
            end
            StWr2: begin
                mw_d   = 1'b1;
                addr_d = SCORE2_ADDR;
                data_d = {{(32 - SCORE_W){1'b0}}, s2_d};
            end
            StOver:  over_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StClr1;
            s1_q     <= '0;
            s2_q     <= '0;
            winner_q <= WIN_NONE;
            mw_q     <= 1'b0;
            addr_q   <= 2'b00;
            data_q   <= '0;
            freeze_q <= 1'b1;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            winner_q <= winner_d;
            mw_q     <= mw_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            freeze_q <= freeze_d;
            over_q   <= over_d;
        end
    end

    assign MW_o        = mw_q;
    assign address_o   = addr_q;
    assign data_o      = data_q;
    assign freeze_o    = freeze_q;
    assign game_over_o = over_q;
    assign winner_o    = winner_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Directed bench for score_sequencer: clear sequence, goal writes, pause length, game over, restart.
module tb_score_sequencer;

    localparam int unsigned PAUSE = 60;

    logic        clk = 1'b0;
    logic        rst;
    logic        goal_p1, goal_p2, new_game, frame_tick;
    logic        mw;
    logic [1:0]  address;
    logic [31:0] data;
    logic        freeze, game_over;
    logic [1:0]  winner;

    int n_tests = 0;
    int n_fail  = 0;
    logic mw_seen;

    score_sequencer #(
        .WIN_SCORE   (9),
        .PAUSE_FRAMES(PAUSE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .goal_p1_i   (goal_p1),
        .goal_p2_i   (goal_p2),
        .new_game_i  (new_game),
        .frame_tick_i(frame_tick),
        .MW_o        (mw),
        .address_o   (address),
        .data_o      (data),
        .freeze_o    (freeze),
        .game_over_o (game_over),
        .winner_o    (winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        mw_seen = mw_seen | mw;
    endtask

    task automatic check_write(input string tag, input logic [1:0] a, input logic [31:0] d);
        check({tag, "_mw"}, {31'd0, mw}, 32'd1);
        check({tag, "_addr"}, {30'd0, address}, {30'd0, a});
        check({tag, "_data"}, data, d);
    endtask

    task automatic do_goal(input logic p1, input logic p2, input int e1, input int e2);
        goal_p1 = p1;
        goal_p2 = p2;
        step();
        goal_p1 = 1'b0;
        goal_p2 = 1'b0;
        check_write("wr1", 2'b00, e1);
        check("wr1_freeze", {31'd0, freeze}, 32'd1);
        step();
        check_write("wr2", 2'b01, e2);
        step();
        check("post_wr_mw", {31'd0, mw}, 32'd0);
    endtask

    // Runs the pause with a stray goal injected; freeze must last exactly PAUSE ticks.
    task automatic run_pause();
        step();
        step();
        mw_seen = 1'b0;
        goal_p1 = 1'b1;
        step();
        goal_p1 = 1'b0;
        for (int i = 1; i <= PAUSE; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (i == PAUSE - 1) check("pause_freeze_hold", {31'd0, freeze}, 32'd1);
            if (i == PAUSE) begin
                check("pause_freeze_end", {31'd0, freeze}, 32'd0);
                check("pause_no_mw", {31'd0, mw_seen}, 32'd0);
            end
            step();
        end
    endtask

    initial begin
        rst        = 1'b1;
        goal_p1    = 1'b0;
        goal_p2    = 1'b0;
        new_game   = 1'b0;
        frame_tick = 1'b0;
        mw_seen    = 1'b0;
        step();
        step();
        check("rst_mw", {31'd0, mw}, 32'd0);
        check("rst_addr", {30'd0, address}, 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_freeze", {31'd0, freeze}, 32'd1);
        check("rst_over", {31'd0, game_over}, 32'd0);
        check("rst_winner", {30'd0, winner}, 32'd0);
        rst = 1'b0;
        step();
        check_write("clr1", 2'b00, 32'd0);
        step();
        check_write("clr2", 2'b01, 32'd0);
        step();
        check("play_mw", {31'd0, mw}, 32'd0);
        check("play_freeze", {31'd0, freeze}, 32'd0);

        // Build s1=2, s2=5.
        do_goal(1'b1, 1'b0, 1, 0); run_pause();
        do_goal(1'b1, 1'b0, 2, 0); run_pause();
        for (int k = 1; k <= 5; k++) begin
            do_goal(1'b0, 1'b1, 2, k);
            run_pause();
        end
        // The stray goals during pauses must not have moved the scores.
        do_goal(1'b1, 1'b0, 3, 5); run_pause();
        do_goal(1'b1, 1'b1, 4, 6); run_pause();
        do_goal(1'b1, 1'b1, 5, 7); run_pause();
        do_goal(1'b1, 1'b1, 6, 8); run_pause();
        do_goal(1'b1, 1'b0, 7, 8); run_pause();
        do_goal(1'b1, 1'b0, 8, 8); run_pause();
        do_goal(1'b1, 1'b1, 9, 9);
        check("over_flag", {31'd0, game_over}, 32'd1);
        check("over_winner", {30'd0, winner}, 32'd3);
        check("over_freeze", {31'd0, freeze}, 32'd1);

        mw_seen = 1'b0;
        goal_p2 = 1'b1;
        step();
        goal_p2 = 1'b0;
        step();
        step();
        check("over_goal_no_mw", {31'd0, mw_seen}, 32'd0);
        check("over_hold_winner", {30'd0, winner}, 32'd3);

        new_game = 1'b1;
        step();
        new_game = 1'b0;
        check_write("ng_clr1", 2'b00, 32'd0);
        check("ng_winner", {30'd0, winner}, 32'd0);
        check("ng_over", {31'd0, game_over}, 32'd0);
        step();
        check_write("ng_clr2", 2'b01, 32'd0);
        step();
        check("ng_play_freeze", {31'd0, freeze}, 32'd0);

        // Reset lands on the edge that would have produced the WR2 write.
        goal_p1 = 1'b1;
        step();
        goal_p1 = 1'b0;
        check_write("pre_rst_wr1", 2'b00, 32'd1);
        rst = 1'b1;
        step();
        check("rst_wr2_mw", {31'd0, mw}, 32'd0);
        check("rst_wr2_freeze", {31'd0, freeze}, 32'd1);
        rst = 1'b0;
        step();
        check_write("rst2_clr1", 2'b00, 32'd0);
        step();
        check_write("rst2_clr2", 2'b01, 32'd0);
        step();
        check("rst2_play", {31'd0, freeze}, 32'd0);
        do_goal(1'b0, 1'b1, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
